// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle MIPS-subset control unit (FETCH/DECODE/EXEC/MEM/WB).
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] EXTop,
    output logic [1:0] ALUop,
    output logic       ALUSrc,
    output logic [1:0] RegDst,
    output logic [1:0] WDsel,
    output logic [1:0] NPCop,
    output logic [2:0] state,
    output logic       done
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_pcwr, w_irwr, w_regwr, w_memwr, w_alusrc, w_done;
    logic [1:0] w_extop, w_aluop, w_regdst, w_wdsel, w_npcop;
    // Immediate-path controls shared by EXEC, MEM and WB of one instruction
    logic [1:0] w_imm_ext;
    logic       w_imm_src;

    assign w_addu = (opcode == c_OP_RTYPE) && (funct == c_FN_ADDU);
    assign w_subu = (opcode == c_OP_RTYPE) && (funct == c_FN_SUBU);
    assign w_jr   = (opcode == c_OP_RTYPE) && (funct == c_FN_JR);
    assign w_ori  = (opcode == c_OP_ORI);
    assign w_lw   = (opcode == c_OP_LW);
    assign w_sw   = (opcode == c_OP_SW);
    assign w_beq  = (opcode == c_OP_BEQ);
    assign w_lui  = (opcode == c_OP_LUI);
    assign w_j    = (opcode == c_OP_J);
    assign w_jal  = (opcode == c_OP_JAL);

    assign w_imm_ext = w_lui ? 2'd2 : ((w_lw || w_sw || w_beq) ? 2'd1 : 2'd0);
    assign w_imm_src = w_ori || w_lui || w_lw || w_sw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = S_FETCH;
        w_pcwr   = 1'b0;
        w_irwr   = 1'b0;
        w_regwr  = 1'b0;
        w_memwr  = 1'b0;
        w_extop  = 2'd0;
        w_aluop  = 2'd0;
        w_alusrc = 1'b0;
        w_regdst = 2'd0;
        w_wdsel  = 2'd0;
        w_npcop  = 2'd0;
        w_done   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwr = 1'b1;
                w_pcwr = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'd2;
                    w_done  = 1'b1;
                    if (w_jal) begin
                        w_regwr  = 1'b1;
                        w_regdst = 2'd2;
                        w_wdsel  = 2'd2;
                    end
                end else if (w_jr) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'd3;
                    w_done  = 1'b1;
                end else if (w_addu || w_subu || w_ori || w_lui ||
                             w_lw || w_sw || w_beq) begin
                    w_next = S_EXEC;
                end else begin
                    w_done = 1'b1;
                end
            end
            S_EXEC: begin
                w_extop  = w_imm_ext;
                w_alusrc = w_imm_src;
                w_aluop  = (w_subu || w_beq) ? 2'd1 :
                           ((w_ori || w_lui) ? 2'd2 : 2'd0);
                if (w_beq) begin
                    // Branch resolves here regardless of the comparison result
                    w_pcwr  = zero;
                    w_npcop = 2'd1;
                    w_done  = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_addu || w_subu || w_ori || w_lui) begin
                    w_next = S_WB;
                end else begin
                    w_done = 1'b1;
                end
            end
            S_MEM: begin
                w_extop  = w_imm_ext;
                w_alusrc = w_imm_src;
                if (w_lw) begin
                    w_next = S_WB;
                end else begin
                    w_memwr = w_sw;
                    w_done  = 1'b1;
                end
            end
            S_WB: begin
                w_extop  = w_imm_ext;
                w_alusrc = w_imm_src;
                w_done   = 1'b1;
                if (w_lw || w_addu || w_subu || w_ori || w_lui) begin
                    w_regwr  = 1'b1;
                    w_wdsel  = w_lw ? 2'd1 : 2'd0;
                    w_regdst = (w_addu || w_subu) ? 2'd1 : 2'd0;
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks the decode outputs so FETCH's enables never leak while held
    assign PCWr   = w_pcwr  & ~reset;
    assign IRWr   = w_irwr  & ~reset;
    assign RegWr  = w_regwr & ~reset;
    assign MemWr  = w_memwr & ~reset;
    assign done   = w_done  & ~reset;
    assign ALUSrc = w_alusrc & ~reset;
    assign EXTop  = reset ? 2'd0 : w_extop;
    assign ALUop  = reset ? 2'd0 : w_aluop;
    assign RegDst = reset ? 2'd0 : w_regdst;
    assign WDsel  = reset ? 2'd0 : w_wdsel;
    assign NPCop  = reset ? 2'd0 : w_npcop;
    assign state  = r_state;

endmodule
`default_nettype wire
